// File: rtl/button_conditioner.sv
// button_conditioner: multi-channel push-button front end.
// Each channel is synchronised, debounced and turned into a clean level plus
// single-cycle press/release events, with long-press detection and optional
// auto-repeat while the button stays held. Every output is registered.
// The release event is named `released` because `release` is a reserved word.

module button_conditioner #(
  parameter int CHANNELS        = 3,
  parameter int CNT_W           = 26,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 25_000_000,
  parameter int REPEAT_CYCLES   = 5_000_000
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [CHANNELS-1:0] btn_in,
  input  logic [CHANNELS-1:0] rpt_en,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] released,
  output logic [CHANNELS-1:0] long_press,
  output logic [CHANNELS-1:0] rpt,
  output logic                any_press
);

  typedef enum logic [1:0] {
    IDLE,    // released, waiting for a rising synchronised input
    ARM,     // candidate press, counting stable-high cycles
    HELD,    // accepted press, running the long/repeat timer
    DISARM   // candidate release, counting stable-low cycles
  } state_t;

  // Terminal counts, compared against the pre-increment counter value.
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;

  state_t              state [CHANNELS];
  logic [CNT_W-1:0]    dcnt  [CHANNELS];
  logic [CNT_W-1:0]    hcnt  [CHANNELS];
  logic [CHANNELS-1:0] long_done;

  // Event strobes for the coming edge; registered into the outputs below.
  logic [CHANNELS-1:0] in_hold;
  logic [CHANNELS-1:0] press_set;
  logic [CHANNELS-1:0] rel_set;
  logic [CHANNELS-1:0] long_set;
  logic [CHANNELS-1:0] rpt_set;

  // Two-flop synchroniser for the asynchronous button pins.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so each flop samples the pre-edge value
    // of the previous stage; blocking here would collapse the two stages.
    if (clr) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  // Decode which events each channel produces on the next edge.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    in_hold   = '0;
    press_set = '0;
    rel_set   = '0;
    long_set  = '0;
    rpt_set   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_hold[i]   = (state[i] == HELD) || (state[i] == DISARM);
      press_set[i] = (state[i] == ARM) && sync2[i] && (dcnt[i] == DEB_LAST);
      rel_set[i]   = (state[i] == DISARM) && !sync2[i] && (dcnt[i] == DEB_LAST);
      // The hold timer runs in HELD and DISARM alike, so a release bounce
      // does not shift long_press; an accepted release drops pending events.
      long_set[i]  = in_hold[i] && !rel_set[i] && !long_done[i]
                     && (hcnt[i] == LONG_LAST);
      rpt_set[i]   = in_hold[i] && !rel_set[i] && long_done[i] && rpt_en[i]
                     && (hcnt[i] == RPT_LAST);
    end
  end

  // Per-channel debounce FSM, hold timer and registered event outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      level      <= '0;
      press      <= '0;
      released   <= '0;
      long_press <= '0;
      rpt        <= '0;
      any_press  <= 1'b0;
      long_done  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state[i] <= IDLE;
        dcnt[i]  <= '0;
        hcnt[i]  <= '0;
      end
    end else begin
      press      <= press_set;
      released   <= rel_set;
      long_press <= long_set;
      rpt        <= rpt_set;
      any_press  <= |press_set;

      for (int i = 0; i < CHANNELS; i++) begin
        // Debounce state machine.
        unique case (state[i])
          IDLE: begin
            if (sync2[i]) begin
              state[i] <= ARM;
              dcnt[i]  <= '0;
            end
          end
          ARM: begin
            if (!sync2[i]) begin
              state[i] <= IDLE;
              dcnt[i]  <= '0;
            end else if (press_set[i]) begin
              state[i]     <= HELD;
              dcnt[i]      <= '0;
              hcnt[i]      <= '0;
              long_done[i] <= 1'b0;
              level[i]     <= 1'b1;
            end else begin
              dcnt[i] <= dcnt[i] + CNT_W'(1);
            end
          end
          HELD: begin
            if (!sync2[i]) begin
              state[i] <= DISARM;
              dcnt[i]  <= '0;
            end
          end
          DISARM: begin
            if (sync2[i]) begin
              state[i] <= HELD;
              dcnt[i]  <= '0;
            end else if (rel_set[i]) begin
              state[i] <= IDLE;
              dcnt[i]  <= '0;
              level[i] <= 1'b0;
            end else begin
              dcnt[i] <= dcnt[i] + CNT_W'(1);
            end
          end
          default: begin
            state[i] <= IDLE;
            dcnt[i]  <= '0;
          end
        endcase

        // Hold timer: long-press first, then auto-repeat while enabled.
        if (rel_set[i]) begin
          hcnt[i]      <= '0;
          long_done[i] <= 1'b0;
        end else if (in_hold[i]) begin
          if (!long_done[i]) begin
            if (long_set[i]) begin
              hcnt[i]      <= '0;
              long_done[i] <= 1'b1;
            end else begin
              hcnt[i] <= hcnt[i] + CNT_W'(1);
            end
          end else if (rpt_en[i]) begin
            hcnt[i] <= rpt_set[i] ? '0 : hcnt[i] + CNT_W'(1);
          end else begin
            hcnt[i] <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with short timing constants.
// A timestamp-based reference model predicts every output every cycle;
// directed scenarios additionally check exact event edges.

module tb_button_conditioner;

  localparam int D = 4;
  localparam int L = 16;
  localparam int R = 5;
  localparam int C = 3;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic [C-1:0] btn_in = '0;
  logic [C-1:0] rpt_en = '0;
  logic [C-1:0] level, press, released, long_press, rpt;
  logic         any_press;

  button_conditioner #(
    .CHANNELS(C), .CNT_W(8), .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(L), .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk), .clr(clr), .btn_in(btn_in), .rpt_en(rpt_en),
    .level(level), .press(press), .released(released),
    .long_press(long_press), .rpt(rpt), .any_press(any_press)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model (timestamps, not counters) ----------
  logic [C-1:0] h1, h2;          // input history: h2 is what the debouncer sees
  logic [C-1:0] m_level, m_ldone;
  logic [C-1:0] e_press, e_rel, e_long, e_rpt;
  int agree_edge [C];            // last edge where seen input matched level
  int press_edge [C];
  int mark       [C];            // start of current repeat interval

  task automatic model_step(input logic [C-1:0] b, input logic [C-1:0] ren, input logic c);
    logic [C-1:0] s;
    logic was_held;
    e_press = '0; e_rel = '0; e_long = '0; e_rpt = '0;
    if (c) begin
      h1 = '0; h2 = '0; m_level = '0; m_ldone = '0;
      for (int i = 0; i < C; i++) agree_edge[i] = cyc;
    end else begin
      s = h2; h2 = h1; h1 = b;
      for (int i = 0; i < C; i++) begin
        was_held = m_level[i];
        // A change is accepted once the new value was seen on D+1 edges in a row.
        if (s[i] == m_level[i]) agree_edge[i] = cyc;
        else if (cyc - agree_edge[i] == D + 1) begin
          agree_edge[i] = cyc;
          m_level[i] = s[i];
          if (s[i]) begin
            e_press[i] = 1'b1; press_edge[i] = cyc; m_ldone[i] = 1'b0;
          end else begin
            e_rel[i] = 1'b1; m_ldone[i] = 1'b0;
          end
        end
        if (was_held && !e_rel[i]) begin
          if (!m_ldone[i]) begin
            if (cyc - press_edge[i] == L) begin
              e_long[i] = 1'b1; m_ldone[i] = 1'b1; mark[i] = cyc;
            end
          end else if (!ren[i]) mark[i] = cyc;
          else if (cyc - mark[i] == R) begin
            e_rpt[i] = 1'b1; mark[i] = cyc;
          end
        end
      end
    end
  endtask

  // ---------------- event logs --------------------------------------------
  int q_press [C][$];
  int q_rel   [C][$];
  int q_long  [C][$];
  int q_rpt   [C][$];
  int q_any   [$];
  logic [C-1:0] seen_level;

  task automatic clear_logs();
    for (int i = 0; i < C; i++) begin
      q_press[i].delete(); q_rel[i].delete(); q_long[i].delete(); q_rpt[i].delete();
    end
    q_any.delete();
    seen_level = '0;
  endtask

  // One clock: model advances on the edge, outputs are compared 1 ns later.
  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step(btn_in, rpt_en, clr);
    #1;
    check("model", {level, press, released, long_press, rpt, any_press},
          {m_level, e_press, e_rel, e_long, e_rpt, |e_press});
    for (int i = 0; i < C; i++) begin
      if (press[i])      q_press[i].push_back(cyc);
      if (released[i])   q_rel[i].push_back(cyc);
      if (long_press[i]) q_long[i].push_back(cyc);
      if (rpt[i])        q_rpt[i].push_back(cyc);
    end
    if (any_press) q_any.push_back(cyc);
    seen_level |= level;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  function automatic int qget(input int q [$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  // ---------------- clean-press vector table ------------------------------
  typedef struct {
    logic btn;
    logic exp_level;
    logic exp_press;
    logic exp_rel;
    logic exp_any;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  int base;
  int t;
  int exp_rpt [$];
  logic [C-1:0] tgt;
  int bounce [C];

  initial begin
    // Entry k is sampled on edge base+k: high for 10 edges, then low.
    // Press accepted 2+D edges after the first high, release 2+D after the fall.
    for (int k = 0; k < NV; k++) begin
      tbl[k].btn       = (k < 10);
      tbl[k].exp_level = (k >= 6) && (k < 16);
      tbl[k].exp_press = (k == 6);
      tbl[k].exp_rel   = (k == 16);
      tbl[k].exp_any   = (k == 6);
    end

    // Reset state.
    clr = 1'b1;
    run(3);
    check("reset_outs", {level, press, released, long_press, rpt, any_press}, 0);
    clr = 1'b0;
    run(5);

    // Clean press / release on channel 0.
    clear_logs();
    for (int k = 0; k < NV; k++) begin
      btn_in[0] = tbl[k].btn;
      tick();
      check("tbl_level",   level[0],    tbl[k].exp_level);
      check("tbl_press",   press[0],    tbl[k].exp_press);
      check("tbl_release", released[0], tbl[k].exp_rel);
      check("tbl_any",     any_press,   tbl[k].exp_any);
    end
    run(4);

    // Bounce rejection on channel 1: 3 high / 1 low, five times.
    clear_logs();
    for (int r = 0; r < 5; r++) begin
      btn_in[1] = 1'b1; run(3);
      btn_in[1] = 1'b0; run(1);
    end
    run(10);
    check("bounce_press",   q_press[1].size(), 0);
    check("bounce_release", q_rel[1].size(),   0);
    check("bounce_level",   seen_level[1],     1'b0);

    // Long press with auto-repeat on channel 2, held 60 cycles.
    clear_logs();
    rpt_en = 3'b100;
    base = cyc + 1;
    btn_in[2] = 1'b1; run(60);
    btn_in[2] = 1'b0; run(12);
    t = base + 2 + D;
    exp_rpt.delete();
    for (int e = t + L + R; e < base + 60 + 2 + D; e += R) exp_rpt.push_back(e);
    check("lp_press",     qget(q_press[2], 0), t);
    check("lp_long_n",    q_long[2].size(),    1);
    check("lp_long",      qget(q_long[2], 0),  t + L);
    check("lp_rpt_n",     q_rpt[2].size(),     exp_rpt.size());
    for (int k = 0; k < exp_rpt.size(); k++)
      check("lp_rpt_edge", qget(q_rpt[2], k), exp_rpt[k]);
    check("lp_release",   qget(q_rel[2], 0),   base + 60 + 2 + D);

    // Same hold without auto-repeat: long_press only.
    clear_logs();
    rpt_en = '0;
    base = cyc + 1;
    btn_in[2] = 1'b1; run(60);
    btn_in[2] = 1'b0; run(12);
    check("norpt_long", qget(q_long[2], 0), base + 2 + D + L);
    check("norpt_rpt",  q_rpt[2].size(),    0);

    // Release bounce on channel 0: drops for 2 cycles while held.
    clear_logs();
    base = cyc + 1;
    btn_in[0] = 1'b1; run(10);
    btn_in[0] = 1'b0; run(2);
    btn_in[0] = 1'b1; run(20);
    btn_in[0] = 1'b0; run(10);
    check("rb_press_n",   q_press[0].size(),   1);
    check("rb_release_n", q_rel[0].size(),     1);
    check("rb_long",      qget(q_long[0], 0),  base + 2 + D + L);
    check("rb_release",   qget(q_rel[0], 0),   base + 32 + 2 + D);

    // All channels rise on the same edge.
    clear_logs();
    base = cyc + 1;
    btn_in = 3'b111; run(12);
    btn_in = 3'b000; run(10);
    for (int i = 0; i < C; i++) check("sim_press", qget(q_press[i], 0), base + 2 + D);
    check("sim_any_n", q_any.size(),   1);
    check("sim_any",   qget(q_any, 0), base + 2 + D);

    // Reset mid-hold: clr on the third edge after press, button kept held.
    clear_logs();
    rpt_en = 3'b111;
    base = cyc + 1;
    btn_in[0] = 1'b1; run(9);
    check("mr_level_before", level[0], 1'b1);
    clr = 1'b1; run(1);
    check("mr_outs_zero", {level, press, released, long_press, rpt, any_press}, 0);
    clr = 1'b0; run(12);
    check("mr_press_n",  q_press[0].size(),   2);
    check("mr_repress",  qget(q_press[0], 1), base + 10 + 2 + D);
    btn_in = '0; rpt_en = '0; run(12);

    // Randomised traffic against the reference model.
    tgt = '0;
    for (int i = 0; i < C; i++) bounce[i] = 0;
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < C; i++) begin
        if ($urandom_range(0, 29) == 0) begin
          tgt[i] = ~tgt[i];
          bounce[i] = $urandom_range(0, 6);
        end
        if (bounce[i] > 0) begin
          btn_in[i] = 1'($urandom_range(0, 1));
          bounce[i]--;
        end else begin
          btn_in[i] = tgt[i];
        end
        if ($urandom_range(0, 39) == 0) rpt_en[i] = ~rpt_en[i];
      end
      clr = ($urandom_range(0, 599) == 0);
      tick();
    end
    clr = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
